// File: rtl/step_clock_ctrl_pkg.sv
// Shared types and constants for the step/free-run CPU clock generator.
package step_ctrl_pkg;

    localparam int CYCLE_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        PULSE_HI,
        PULSE_LO,
        HALTED
    } step_state_t;

endpackage

// File: rtl/step_clock_ctrl_if.sv
// Control/status bundle between the board-level inputs, the clock generator and peek_logic.
interface step_clock_ctrl_if;
    import step_ctrl_pkg::*;

    logic               StepKey;
    logic               RunMode;
    logic [31:0]        PC;
    logic [31:0]        BreakAddr;
    logic               BreakEnable;
    logic               CpuClk;
    logic               StepTick;
    logic               Running;
    logic               BreakHit;
    logic [CYCLE_W-1:0] CycleCount;

    modport master (
        output StepKey, RunMode, PC, BreakAddr, BreakEnable,
        input  CpuClk, StepTick, Running, BreakHit, CycleCount
    );

    modport slave (
        input  StepKey, RunMode, PC, BreakAddr, BreakEnable,
        output CpuClk, StepTick, Running, BreakHit, CycleCount
    );

endinterface

// File: rtl/step_clock_ctrl_sync2.sv
// Two-flop synchronizer, async active-low reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/step_clock_ctrl.sv
// CpuClk generator: single-step per key press or free-run at RUN_PERIOD, with an
// optional PC breakpoint enabled by defining STEP_BREAKPOINT_EN.
module step_clock_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int PULSE_HIGH = 1024,
    parameter int RUN_PERIOD = 25000000,
    parameter int CNT_W      = 26
) (
    input  logic             CLK50M,
    input  logic             reset_n,
    step_clock_ctrl_if.slave bus
);

    logic               w_step_s;
    logic               w_run_s;
    logic               r_step_d;
    logic               r_step_rise;
    step_state_t        r_state;
    step_state_t        w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_single;
    logic               w_start_single;
    logic               w_enter_hi;
    logic               w_brk_match;
    logic               r_cpuclk;
    logic               r_tick;
    logic               r_running;
    logic               r_break;
    logic [CYCLE_W-1:0] r_cycles;

    sync2 u_sync_step (.clk(CLK50M), .rst_n(reset_n), .i_d(bus.StepKey), .o_q(w_step_s));
    sync2 u_sync_run  (.clk(CLK50M), .rst_n(reset_n), .i_d(bus.RunMode), .o_q(w_run_s));

`ifdef STEP_BREAKPOINT_EN
    assign w_brk_match = bus.BreakEnable && (bus.PC == bus.BreakAddr);
`else
    logic w_unused_brk;
    assign w_unused_brk = ^{bus.BreakEnable, bus.PC, bus.BreakAddr};
    assign w_brk_match  = 1'b0;
`endif

    // Registered one-cycle strobe on each synchronized key press.
    always_ff @(posedge CLK50M or negedge reset_n) begin
        if (!reset_n) begin
            r_step_d    <= 1'b0;
            r_step_rise <= 1'b0;
        end else begin
            r_step_d    <= w_step_s;
            r_step_rise <= w_step_s & ~r_step_d;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_start_single = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_run_s || r_step_rise) w_next = PULSE_HI;
            end
            PULSE_HI: begin
                if (r_cnt == CNT_W'(PULSE_HIGH - 1))
                    w_next = (w_run_s && !r_single) ? PULSE_LO : IDLE;
            end
            PULSE_LO: begin
                if (r_cnt == CNT_W'(RUN_PERIOD - 1)) begin
                    if (w_brk_match)  w_next = HALTED;
                    else if (w_run_s) w_next = PULSE_HI;
                    else              w_next = IDLE;
                end
            end
            HALTED: begin
                if (!w_run_s) begin
                    w_next = IDLE;
                end else if (r_step_rise) begin
                    // Stepping past a breakpoint yields one pulse, never a resumed run.
                    w_next         = PULSE_HI;
                    w_start_single = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
        w_enter_hi = (w_next == PULSE_HI) && (r_state != PULSE_HI);
    end

    always_ff @(posedge CLK50M or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_single  <= 1'b0;
            r_cpuclk  <= 1'b0;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
            r_break   <= 1'b0;
            r_cycles  <= '0;
        end else begin
            r_state <= w_next;
            if (w_enter_hi)
                r_cnt <= '0;
            else if (w_next == PULSE_HI || w_next == PULSE_LO)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            if (w_enter_hi) r_single <= w_start_single;
            r_cpuclk  <= (w_next == PULSE_HI);
            r_tick    <= w_enter_hi;
            r_running <= (w_next == PULSE_HI || w_next == PULSE_LO) && w_run_s;
            r_break   <= (w_next == HALTED);
            if (w_enter_hi) r_cycles <= r_cycles + 1'b1;
        end
    end

    assign bus.CpuClk     = r_cpuclk;
    assign bus.StepTick   = r_tick;
    assign bus.Running    = r_running;
    assign bus.BreakHit   = r_break;
    assign bus.CycleCount = r_cycles;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Bench for step_clock_ctrl: table vectors, directed sequences and a randomized run vs. a timing model.
module tb_step_clock_ctrl;
    import step_ctrl_pkg::*;

    localparam int PH = 4;
    localparam int RP = 10;
    localparam int CW = 4;

    logic CLK50M  = 1'b0;
    logic reset_n = 1'b0;

    step_clock_ctrl_if bus();

    step_clock_ctrl #(.PULSE_HIGH(PH), .RUN_PERIOD(RP), .CNT_W(CW)) dut (
        .CLK50M (CLK50M),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 CLK50M = ~CLK50M;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        step;
        logic        run;
        logic        clk;
        logic        tick;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[13];

    // Reference model: pulses described by their start edge; inputs via the 3-edge key / 2-edge mode delay.
    logic        kh[4];
    logic        rh[2];
    int          m_mode;
    int          m_t0;
    int          m_n;
    bit          m_single;
    logic [31:0] m_cnt;
    logic        m_clk, m_tick, m_run_o, m_brk_o;

    function automatic logic [35:0] pack(input logic c, input logic t, input logic r,
                                         input logic b, input logic [31:0] n);
        return {c, t, r, b, n};
    endfunction

    function automatic logic [35:0] outs();
        return {bus.CpuClk, bus.StepTick, bus.Running, bus.BreakHit, bus.CycleCount};
    endfunction

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got clk/tick/run/brk/cnt=%b%b%b%b/%h expected %b%b%b%b/%h", nm,
                     act[35], act[34], act[33], act[32], act[31:0],
                     exp[35], exp[34], exp[33], exp[32], exp[31:0]);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) kh[i] = 1'b0;
        rh[0] = 1'b0; rh[1] = 1'b0;
        m_mode = 0; m_t0 = 0; m_n = 0; m_single = 0; m_cnt = '0;
        m_clk = 0; m_tick = 0; m_run_o = 0; m_brk_o = 0;
    endtask

    task automatic model_step();
        bit rise, run, brk, start, sgl;
        int ph;
        m_n++;
        rise = kh[2] & ~kh[3];
        run  = rh[1];
`ifdef STEP_BREAKPOINT_EN
        brk = bus.BreakEnable && (bus.PC == bus.BreakAddr);
`else
        brk = 1'b0;
`endif
        start = 0;
        sgl   = 0;
        if (m_mode == 0) begin
            if (run || rise) start = 1;
        end else if (m_mode == 1) begin
            ph = m_n - m_t0;
            if (ph == PH) begin
                if (!(run && !m_single)) m_mode = 0;
            end else if (ph == RP) begin
                if (brk)      m_mode = 2;
                else if (run) start = 1;
                else          m_mode = 0;
            end
        end else begin
            if (!run) m_mode = 0;
            else if (rise) begin start = 1; sgl = 1; end
        end
        if (start) begin
            m_mode = 1; m_t0 = m_n; m_cnt = m_cnt + 1; m_single = sgl;
        end
        kh[3] = kh[2]; kh[2] = kh[1]; kh[1] = kh[0]; kh[0] = bus.StepKey;
        rh[1] = rh[0]; rh[0] = bus.RunMode;
        m_clk   = (m_mode == 1) && ((m_n - m_t0) < PH);
        m_tick  = start;
        m_run_o = (m_mode == 1) && run;
        m_brk_o = (m_mode == 2);
    endtask

    task automatic cyc();
        @(posedge CLK50M);
        model_step();
        @(negedge CLK50M);
    endtask

    task automatic do_reset();
        @(negedge CLK50M);
        reset_n = 1'b0;
        bus.StepKey = 0; bus.RunMode = 0; bus.PC = '0; bus.BreakAddr = '0; bus.BreakEnable = 0;
        m_reset();
        repeat (2) @(negedge CLK50M);
        chk("reset_state", outs(), '0);
        reset_n = 1'b1;
    endtask

    initial begin
        // Single step with key bounces that land while the pulse is still high.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd1};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd1};

        bus.StepKey = 0; bus.RunMode = 0; bus.PC = '0; bus.BreakAddr = '0; bus.BreakEnable = 0;
        m_reset();

        do_reset();
        for (int i = 0; i < 13; i++) begin
            bus.StepKey = tbl[i].step;
            bus.RunMode = tbl[i].run;
            cyc();
            chk($sformatf("step_tbl[%0d]", i), outs(),
                pack(tbl[i].clk, tbl[i].tick, 1'b0, 1'b0, tbl[i].cnt));
        end

        // Free-run: 10-cycle period, 4 high.
        do_reset();
        bus.RunMode = 1;
        for (int i = 0; i < 100; i++) begin
            cyc();
            chk($sformatf("freerun[%0d]", i), outs(),
                pack((i >= 2) && ((i - 2) % RP < PH), (i >= 2) && ((i - 2) % RP == 0),
                     i >= 2, 1'b0, (i >= 2) ? 32'((i - 2) / RP + 1) : 32'd0));
        end

        // RunMode dropped two cycles into the high phase.
        do_reset();
        bus.RunMode = 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) bus.RunMode = 0;
            cyc();
            chk($sformatf("run_drop[%0d]", i), outs(),
                pack(i >= 2 && i <= 5, i == 2, i >= 2 && i <= 5, 1'b0, (i >= 2) ? 32'd1 : 32'd0));
        end

        // Breakpoint during free-run, then step past it.
        do_reset();
        bus.BreakEnable = 1; bus.BreakAddr = 32'h10; bus.PC = 32'h0; bus.RunMode = 1;
        for (int i = 0; i < 31; i++) begin
            if (i == 5) bus.PC = 32'h10;
            cyc();
`ifdef STEP_BREAKPOINT_EN
            chk($sformatf("brk_run[%0d]", i), outs(),
                pack(i >= 2 && i <= 5, i == 2, i >= 2 && i < 12, i >= 12, (i >= 2) ? 32'd1 : 32'd0));
`else
            chk($sformatf("brk_off[%0d]", i), outs(),
                pack((i >= 2) && ((i - 2) % RP < PH), (i >= 2) && ((i - 2) % RP == 0),
                     i >= 2, 1'b0, (i >= 2) ? 32'((i - 2) / RP + 1) : 32'd0));
`endif
        end
`ifdef STEP_BREAKPOINT_EN
        for (int j = 31; j < 61; j++) begin
            bus.StepKey = (j == 31);
            bus.RunMode = (j < 34);
            cyc();
            chk($sformatf("brk_step[%0d]", j), outs(),
                pack(j >= 34 && j <= 37, j == 34, j == 34 || j == 35, j < 34,
                     (j >= 34) ? 32'd2 : 32'd1));
        end
`endif

        // Randomized run against the model.
        do_reset();
        bus.BreakAddr = 32'h10;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)   bus.StepKey = ~bus.StepKey;
            if ($urandom_range(0, 79) == 0)  bus.RunMode = ~bus.RunMode;
            if ($urandom_range(0, 199) == 0) bus.BreakEnable = ~bus.BreakEnable;
            bus.PC = ($urandom_range(0, 3) == 0) ? 32'h10 : 32'($urandom);
            cyc();
            chk("random", outs(), pack(m_clk, m_tick, m_run_o, m_brk_o, m_cnt));
        end

        // Counter wrap, then async reset in the middle of a high phase.
        do_reset();
        force dut.r_cycles = 32'hFFFF_FFFF;
        #1;
        release dut.r_cycles;
        chk("preload", {4'b0, bus.CycleCount}, {4'b0, 32'hFFFF_FFFF});
        bus.StepKey = 1;
        cyc();
        bus.StepKey = 0;
        repeat (3) cyc();
        chk("wrap", outs(), pack(1'b1, 1'b1, 1'b0, 1'b0, 32'd0));
        cyc();
        chk("mid_hi", outs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", outs(), '0);
        @(negedge CLK50M);
        reset_n = 1'b1;
        repeat (3) cyc();
        chk("after_reset", outs(), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/step_clock_ctrl.md
Name: step_clock_ctrl

Overview:
- Upstream of the arm core. Generates the CPU clock, CpuClk, from the CLK50M domain, replacing direct use of the debounced KEY0 level as the clock.
- Two modes:
  - Single-step: one clock pulse per debounced key press.
  - Free-run: periodic pulses at a programmable rate.
- Optional PC breakpoint halts free-run.
- Exports a step tick and a retired-cycle counter for peek_logic.

Parameters:
- PULSE_HIGH, 1024: CLK50M cycles that CpuClk is held high per pulse; legal range 1..2^CNT_W-1.
- RUN_PERIOD, 25000000: total CLK50M cycles per free-run pulse (high plus low); must be > PULSE_HIGH.
- CNT_W, 26: width of the internal phase counter; must hold RUN_PERIOD-1.

Ports:
- CLK50M  in  1  system clock, the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- StepKey  in  1  debounced step request, active-high, asynchronous to CLK50M.
- RunMode  in  1  1 = free-run, 0 = single-step; from a slide switch, asynchronous.
- PC  in  32  current fetch PC from the core; sampled in CLK50M domain.
- BreakAddr  in  32  breakpoint address.
- BreakEnable  in  1  arms the breakpoint.
- CpuClk  out  1  registered CPU clock.
- StepTick  out  1  one-CLK50M-cycle strobe coincident with each CpuClk rising edge.
- Running  out  1  high while in free-run (states HI/LO with RunMode=1).
- BreakHit  out  1  high while in HALTED.
- CycleCount  out  32  number of CpuClk rising edges since reset.

Behaviour:
- Reset (reset_n=0, async): state IDLE, CpuClk=0, StepTick=0, Running=0, BreakHit=0, CycleCount=0, synchronizers and phase counter cleared.
- Synchronizers:
  - StepKey and RunMode each pass a 2-flop synchronizer.
  - A rising-edge detector on synchronized StepKey gives step_rise.
- States (FSM): IDLE, PULSE_HI, PULSE_LO, HALTED.
- IDLE (CpuClk=0):
  - If sync RunMode=1, go to PULSE_HI.
  - Else if step_rise, go to PULSE_HI.
- Entering PULSE_HI:
  - CpuClk=1 and StepTick=1 for exactly that one cycle.
  - CycleCount += 1, mod 2^32 (wraps 0xFFFFFFFF -> 0).
  - Phase counter = 0.
- PULSE_HI: counter counts up. At count PULSE_HIGH-1:
  - Go to PULSE_LO if sync RunMode=1.
  - Else go to IDLE.
- PULSE_LO (CpuClk=0): counter continues. At count RUN_PERIOD-1:
  - If breakpoint match, go to HALTED.
  - Else if RunMode=1, go to PULSE_HI.
  - Else go to IDLE.
- HALTED (CpuClk=0, BreakHit=1):
  - Sync RunMode=0 goes to IDLE.
  - step_rise performs one single pulse: go to PULSE_HI, then IDLE. This lets the user step past the breakpoint.
- Latency: StepKey rising at CLK50M edge k gives CpuClk high after edge k+3 (2 sync flops, edge register, registered output).
- Boundary conditions:
  - step_rise in any state other than IDLE or HALTED is dropped, not queued.
  - RunMode falling mid-pulse completes the current high phase, then goes to IDLE. CpuClk is never truncated below PULSE_HIGH.
  - Breakpoint match is evaluated only at the end of PULSE_LO, once PC has settled after the prior rising edge.
  - reset_n asserted mid-pulse forces CpuClk=0 immediately.
- CpuClk is driven only from a flop; no combinational glitches.

Optional Feature:
- Macro: STEP_BREAKPOINT_EN.
- Defined: breakpoint match = BreakEnable & (PC == BreakAddr), as above.
- Undefined: BreakAddr and BreakEnable are ignored (ports kept for a uniform top level), match is constant 0, HALTED is unreachable, BreakHit tied 0.

Decomposition:
- Package step_ctrl_pkg:
  - typedef enum logic [1:0] step_state_t {IDLE, PULSE_HI, PULSE_LO, HALTED}.
  - Constant CYCLE_W = 32.
- Sub-module sync2: a 2-flop synchronizer with async active-low reset to 0, instantiated twice (StepKey, RunMode).

Test Plan:
All scenarios use PULSE_HIGH=4, RUN_PERIOD=10, CNT_W=4.
1. Reset release, RunMode=0, one StepKey rise: CpuClk high 3 edges later for exactly 4 cycles, StepTick one cycle, CycleCount=1, then IDLE.
2. StepKey toggled twice within one pulse: only one pulse produced; CycleCount=1.
3. RunMode=1 held for 100 cycles: pulses every 10 cycles, high 4 and low 6; Running=1; CycleCount increments by 1 per period.
4. RunMode dropped 2 cycles into PULSE_HI: high phase still lasts 4 cycles, then IDLE; CpuClk=0 thereafter.
5. With STEP_BREAKPOINT_EN, BreakEnable=1, BreakAddr=0x10, PC driven to 0x10 during run:
   - Enters HALTED after that PULSE_LO; BreakHit=1; no further pulses.
   - A StepKey rise gives exactly one pulse, then IDLE.
6. CycleCount preloaded near wrap via 0xFFFFFFFF steps (force): the next step gives CycleCount=0. reset_n pulsed low mid-PULSE_HI gives CpuClk=0 the same cycle and all outputs at reset values.
